// File: rtl/seq_primitives.sv
// Three independent sequential primitives: a loadable up-counter, an enabled register and a
// parallel-load shift register that emits its storage MSB-first in SR_OUTWIDTH-bit chunks.
// Defining SEQ_PRIMITIVES_CNT_SAT_EN makes the counter saturate at all-ones instead of wrapping.
module seq_primitives #(
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned REG_WIDTH   = 8,
  parameter int unsigned SR_INWIDTH  = 8,
  parameter int unsigned SR_OUTWIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_WIDTH-1:0]   cnt_d,
  input  logic                   cnt_load,
  input  logic                   cnt_up,
  output logic [CNT_WIDTH-1:0]   cnt_q,
  input  logic [REG_WIDTH-1:0]   reg_d,
  input  logic                   reg_en,
  output logic [REG_WIDTH-1:0]   reg_q,
  input  logic [SR_INWIDTH-1:0]  sr_d,
  input  logic                   sr_reload,
  input  logic                   sr_shift,
  output logic [SR_OUTWIDTH-1:0] sr_q
);

  localparam int unsigned SrChunks = (SR_INWIDTH + SR_OUTWIDTH - 1) / SR_OUTWIDTH;
  localparam int unsigned SrStoreW = SrChunks * SR_OUTWIDTH;
  localparam int unsigned SrPad    = SrStoreW - SR_INWIDTH;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_val_q, cnt_val_d;
  logic [REG_WIDTH-1:0] reg_val_q, reg_val_d;
  logic [SrStoreW-1:0]  sr_store_q, sr_store_d;

  always_comb begin
    cnt_val_d = cnt_val_q;
    if (cnt_load) begin
      cnt_val_d = cnt_d;
    end else if (cnt_up) begin
`ifdef SEQ_PRIMITIVES_CNT_SAT_EN
      if (!(&cnt_val_q)) begin
        cnt_val_d = cnt_val_q + CntOne;
      end
`else
      cnt_val_d = cnt_val_q + CntOne;
`endif
    end
  end

  always_comb begin
    reg_val_d = reg_en ? reg_d : reg_val_q;
  end

  // Reload left-aligns sr_d so the first chunk out is its MSBs; low pad bits stay zero.
  always_comb begin
    sr_store_d = sr_store_q;
    if (sr_reload) begin
      sr_store_d = SrStoreW'(sr_d) << SrPad;
    end else if (sr_shift) begin
      sr_store_d = sr_store_q << SR_OUTWIDTH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_val_q  <= '0;
      reg_val_q  <= '0;
      sr_store_q <= '0;
    end else begin
      cnt_val_q  <= cnt_val_d;
      reg_val_q  <= reg_val_d;
      sr_store_q <= sr_store_d;
    end
  end

  assign cnt_q = cnt_val_q;
  assign reg_q = reg_val_q;
  assign sr_q  = sr_store_q[SrStoreW-1 -: SR_OUTWIDTH];

endmodule

// File: tb/tb_seq_primitives.sv
// Directed bench: instance a uses default widths (8/8/8/2), instance b uses a 3-bit counter and
// a 7-bit shift register with 2-bit chunks to exercise wrap/saturation and the padded load.
module tb_seq_primitives;

  logic clk;
  logic rst_n;

  logic [7:0] cnt_d_a, reg_d_a, sr_d_a, cnt_q_a, reg_q_a;
  logic       cnt_load_a, cnt_up_a, reg_en_a, sr_reload_a, sr_shift_a;
  logic [1:0] sr_q_a;

  logic [2:0] cnt_d_b, cnt_q_b;
  logic [7:0] reg_d_b, reg_q_b;
  logic [6:0] sr_d_b;
  logic       cnt_load_b, cnt_up_b, reg_en_b, sr_reload_b, sr_shift_b;
  logic [1:0] sr_q_b;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_PRIMITIVES_CNT_SAT_EN
  localparam logic [7:0] CntTopA = 8'hFF;
  localparam logic [2:0] CntTopB = 3'd7;
`else
  localparam logic [7:0] CntTopA = 8'h00;
  localparam logic [2:0] CntTopB = 3'd0;
`endif

  seq_primitives u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_d     (cnt_d_a),
    .cnt_load  (cnt_load_a),
    .cnt_up    (cnt_up_a),
    .cnt_q     (cnt_q_a),
    .reg_d     (reg_d_a),
    .reg_en    (reg_en_a),
    .reg_q     (reg_q_a),
    .sr_d      (sr_d_a),
    .sr_reload (sr_reload_a),
    .sr_shift  (sr_shift_a),
    .sr_q      (sr_q_a)
  );

  seq_primitives #(
    .CNT_WIDTH   (3),
    .REG_WIDTH   (8),
    .SR_INWIDTH  (7),
    .SR_OUTWIDTH (2)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_d     (cnt_d_b),
    .cnt_load  (cnt_load_b),
    .cnt_up    (cnt_up_b),
    .cnt_q     (cnt_q_b),
    .reg_d     (reg_d_b),
    .reg_en    (reg_en_b),
    .reg_q     (reg_q_b),
    .sr_d      (sr_d_b),
    .sr_reload (sr_reload_b),
    .sr_shift  (sr_shift_b),
    .sr_q      (sr_q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cnt_load;
    logic       cnt_up;
    logic [7:0] cnt_d;
    logic       reg_en;
    logic [7:0] reg_d;
    logic       sr_reload;
    logic       sr_shift;
    logic [7:0] sr_d;
    logic [7:0] exp_cnt;
    logic [7:0] exp_reg;
    logic [1:0] exp_sr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    cnt_load_a = 0; cnt_up_a = 0; reg_en_a = 0; sr_reload_a = 0; sr_shift_a = 0;
  endtask

  task automatic idle_b();
    cnt_load_b = 0; cnt_up_b = 0; reg_en_b = 0; sr_reload_b = 0; sr_shift_b = 0;
  endtask

  initial begin
    // ld up d     en d      rl sh d             cnt    reg    sr
    vecs[0]  = '{0, 1, 8'h00, 1, 8'hA5, 1, 0, 8'b10011100, 8'h01, 8'hA5, 2'b10};
    vecs[1]  = '{0, 1, 8'h00, 0, 8'h3C, 0, 1, 8'h00,       8'h02, 8'hA5, 2'b01};
    vecs[2]  = '{0, 1, 8'h00, 0, 8'h3C, 0, 1, 8'h00,       8'h03, 8'hA5, 2'b11};
    vecs[3]  = '{0, 1, 8'h00, 0, 8'h3C, 0, 1, 8'h00,       8'h04, 8'hA5, 2'b00};
    vecs[4]  = '{0, 1, 8'h00, 0, 8'h3C, 0, 1, 8'h00,       8'h05, 8'hA5, 2'b00};
    vecs[5]  = '{1, 1, 8'h00, 1, 8'h3C, 0, 1, 8'h00,       8'h00, 8'h3C, 2'b00};
    vecs[6]  = '{1, 0, 8'hFE, 0, 8'h11, 1, 1, 8'hC3,       8'hFE, 8'h3C, 2'b11};
    vecs[7]  = '{0, 1, 8'h00, 0, 8'h00, 0, 1, 8'h00,       8'hFF, 8'h3C, 2'b00};
    vecs[8]  = '{0, 1, 8'h00, 0, 8'h00, 0, 0, 8'h00,       CntTopA, 8'h3C, 2'b00};
    vecs[9]  = '{0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00,       CntTopA, 8'h3C, 2'b00};
    vecs[10] = '{0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00,       CntTopA, 8'h3C, 2'b11};
    vecs[11] = '{0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00,       CntTopA, 8'h3C, 2'b00};

    rst_n = 0;
    cnt_d_a = '0; reg_d_a = '0; sr_d_a = '0;
    cnt_d_b = '0; reg_d_b = '0; sr_d_b = '0;
    idle_a();
    idle_b();
    #1;
    chk("reset_cnt_a", 32'(cnt_q_a), 32'h0);
    chk("reset_reg_a", 32'(reg_q_a), 32'h0);
    chk("reset_sr_a", 32'(sr_q_a), 32'h0);
    chk("reset_cnt_b", 32'(cnt_q_b), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();

    for (int i = 0; i < 12; i++) begin
      cnt_load_a  = vecs[i].cnt_load;
      cnt_up_a    = vecs[i].cnt_up;
      cnt_d_a     = vecs[i].cnt_d;
      reg_en_a    = vecs[i].reg_en;
      reg_d_a     = vecs[i].reg_d;
      sr_reload_a = vecs[i].sr_reload;
      sr_shift_a  = vecs[i].sr_shift;
      sr_d_a      = vecs[i].sr_d;
      tick();
      chk($sformatf("vec%0d_cnt", i), 32'(cnt_q_a), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_reg", i), 32'(reg_q_a), 32'(vecs[i].exp_reg));
      chk($sformatf("vec%0d_sr", i), 32'(sr_q_a), 32'(vecs[i].exp_sr));
    end
    idle_a();

    // 3-bit counter: eight increments from 0 wrap (or saturate).
    chk("b_cnt_start", 32'(cnt_q_b), 32'h0);
    cnt_up_b = 1;
    for (int i = 0; i < 7; i++) tick();
    chk("b_cnt_seven", 32'(cnt_q_b), 32'd7);
    tick();
    chk("b_cnt_eighth", 32'(cnt_q_b), 32'(CntTopB));
    cnt_up_b = 0;
    cnt_load_b = 1; cnt_d_b = 3'd2;
    tick();
    chk("b_cnt_load", 32'(cnt_q_b), 32'd2);
    cnt_load_b = 0;

    // 7-bit load into 8-bit storage: 1011011 -> 10 11 01 10(pad).
    sr_reload_b = 1; sr_d_b = 7'b1011011;
    tick();
    chk("b_sr_load", 32'(sr_q_b), 32'b10);
    sr_reload_b = 0; sr_shift_b = 1;
    tick();
    chk("b_sr_sh1", 32'(sr_q_b), 32'b11);
    tick();
    chk("b_sr_sh2", 32'(sr_q_b), 32'b01);
    tick();
    chk("b_sr_sh3_pad", 32'(sr_q_b), 32'b10);
    tick();
    chk("b_sr_sh4_empty", 32'(sr_q_b), 32'b00);
    sr_reload_b = 1; sr_d_b = 7'b0111000;
    #1;
    chk("b_sr_no_comb_path", 32'(sr_q_b), 32'b00);
    tick();
    chk("b_sr_reload_prio", 32'(sr_q_b), 32'b01);
    sr_reload_b = 0;
    tick();
    chk("b_sr_after_prio", 32'(sr_q_b), 32'b11);
    idle_b();

    // Build cnt=3, reg=A5, SR shifted once, then reset between edges.
    cnt_load_a = 1; cnt_d_a = 8'd1; reg_en_a = 1; reg_d_a = 8'hA5;
    sr_reload_a = 1; sr_d_a = 8'b10011100;
    tick();
    idle_a();
    cnt_up_a = 1; sr_shift_a = 1;
    tick();
    sr_shift_a = 0;
    tick();
    chk("pre_rst_cnt", 32'(cnt_q_a), 32'd3);
    chk("pre_rst_reg", 32'(reg_q_a), 32'hA5);
    chk("pre_rst_sr", 32'(sr_q_a), 32'b01);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_cnt", 32'(cnt_q_a), 32'h0);
    chk("async_rst_reg", 32'(reg_q_a), 32'h0);
    chk("async_rst_sr", 32'(sr_q_a), 32'h0);
    chk("async_rst_cnt_b", 32'(cnt_q_b), 32'h0);
    tick();
    chk("rst_held_cnt", 32'(cnt_q_a), 32'h0);
    #2;
    rst_n = 1;
    tick();
    chk("post_rst_first_edge", 32'(cnt_q_a), 32'd1);
    idle_a();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_primitives.md
SEQ_PRIMITIVES -- requirements
Module: seq_primitives

Interface
REQ-001 The block SHALL provide three independent sequential primitives: counter (CNT), enabled register (REG) and parallel-load shift register (SR), sharing clk and rst_n.
REQ-002 Parameter CNT_WIDTH, default 8, counter bit width (>=1).
REQ-003 Parameter REG_WIDTH, default 8, register bit width (>=1).
REQ-004 Parameter SR_INWIDTH, default 8, shift-register parallel load width (>=1).
REQ-005 Parameter SR_OUTWIDTH, default 2, shift-register output chunk width (1..SR_INWIDTH).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 cnt_d  input  CNT_WIDTH  counter load value.
REQ-009 cnt_load  input  1  load cnt_d into counter.
REQ-010 cnt_up  input  1  increment counter.
REQ-011 cnt_q  output  CNT_WIDTH  counter value.
REQ-012 reg_d  input  REG_WIDTH  register data in.
REQ-013 reg_en  input  1  capture reg_d.
REQ-014 reg_q  output  REG_WIDTH  register value.
REQ-015 sr_d  input  SR_INWIDTH  shift-register parallel data.
REQ-016 sr_reload  input  1  parallel load of sr_d.
REQ-017 sr_shift  input  1  advance one chunk.
REQ-018 sr_q  output  SR_OUTWIDTH  current most-significant chunk.

Function
REQ-019 Counter, per rising edge: cnt_load=1 -> cnt_q<=cnt_d; else cnt_up=1 -> cnt_q<=cnt_q+1; else hold; cnt_load has priority over cnt_up.
REQ-020 Counter increment SHALL wrap modulo 2^CNT_WIDTH (all-ones +1 -> 0) unless REQ-031 applies.
REQ-021 Register: reg_en=1 -> reg_q<=reg_d on next edge; reg_en=0 -> hold.
REQ-022 SR internal storage SHALL be SR_CHUNKS*SR_OUTWIDTH bits, SR_CHUNKS=ceil(SR_INWIDTH/SR_OUTWIDTH).
REQ-023 sr_reload SHALL load sr_d left-aligned (MSB at storage MSB), unused low pad bits zero.
REQ-024 sr_shift SHALL shift storage left by SR_OUTWIDTH, filling zeros at LSB.
REQ-025 sr_q SHALL equal the top SR_OUTWIDTH storage bits, combinationally from state (MSB-first chunk order).
REQ-026 sr_reload SHALL have priority over sr_shift when both asserted; neither -> hold.
REQ-027 After SR_CHUNKS shifts without reload, sr_q SHALL be 0; further shifts keep 0.
REQ-028 All outputs SHALL be registered-state outputs with one-cycle latency from control to visible value; no combinational input-to-output paths.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force cnt_q, reg_q, SR storage (and sr_q) to 0, overriding all controls.
REQ-030 rst_n deassertion SHALL be synchronous-safe: first update occurs on the first rising edge with rst_n high; reset mid-operation discards in-progress counts/shifts.

Configuration
REQ-031 Macro SEQ_PRIMITIVES_CNT_SAT_EN: defined -> counter saturates, cnt_up at all-ones holds all-ones (load still works); undefined -> wrap per REQ-020.

Verification
REQ-032 CNT: reset, cnt_up=1 for 5 cycles -> cnt_q=5; assert cnt_load with cnt_d=0 and cnt_up=1 -> cnt_q=0 next edge.
REQ-033 CNT wrap (CNT_WIDTH=3): count from 0 with cnt_up for 8 edges -> cnt_q=0 without macro, 7 with SEQ_PRIMITIVES_CNT_SAT_EN.
REQ-034 REG: reg_d=8'hA5,reg_en=1 one edge -> reg_q=8'hA5; reg_d=8'h3C,reg_en=0 -> reg_q stays 8'hA5.
REQ-035 SR (8/2): reload sr_d=8'b10_01_11_00 -> sr_q=2'b10; successive shifts -> 01, 11, 00, then 00.
REQ-036 SR (7/2): reload 7'b1011011 -> sr_q sequence 10,11,01,10 (pad), with simultaneous reload+shift reloading.
REQ-037 Async reset mid-count (cnt_q=3, reg_q=8'hA5, SR shifted): drop rst_n between edges -> all outputs 0 immediately, before next clk edge.
